// File: rtl/lsb_gen_if.sv
// rtl/lsb_gen_if.sv - dispatch, broadcast, cache and result signals of the load/store buffer
interface lsb_gen_if #(
    parameter int TAG_W = 5,
    parameter int DAT_W = 32,
    parameter int OP_W  = 5,
    parameter int CDB_N = 2
);
    logic                   iROB_En;
    logic [OP_W-1:0]        iROB_Op;
    logic [DAT_W-1:0]       iROB_Imm;
    logic [TAG_W-1:0]       iROB_Qs1;
    logic [TAG_W-1:0]       iROB_Qs2;
    logic [DAT_W-1:0]       iROB_Vs1;
    logic [DAT_W-1:0]       iROB_Vs2;
    logic [TAG_W-1:0]       iROB_Qd;
    logic                   iROB_Cs;
    logic                   iROB_Mp;
    logic [CDB_N-1:0]       iEX_En;
    logic [CDB_N*TAG_W-1:0] iEX_Qd;
    logic [CDB_N*DAT_W-1:0] iEX_Vd;
    logic                   oDC_En;
    logic                   oDC_Rw;
    logic [2:0]             oDC_Len;
    logic [DAT_W-1:0]       oDC_Add;
    logic [DAT_W-1:0]       oDC_Dat;
    logic                   iDC_En;
    logic [DAT_W-1:0]       iDC_Dat;
    logic                   oRS_En;
    logic [TAG_W-1:0]       oRS_Qd;
    logic [DAT_W-1:0]       oRS_Vd;
    logic                   oROB_En;
    logic [TAG_W-1:0]       oROB_Qd;
    logic [DAT_W-1:0]       oROB_Vd;
    logic                   iIOB_Full;
    logic                   oIF_Full;

    modport master (
        output iROB_En, iROB_Op, iROB_Imm, iROB_Qs1, iROB_Qs2, iROB_Vs1, iROB_Vs2, iROB_Qd,
        output iROB_Cs, iROB_Mp, iEX_En, iEX_Qd, iEX_Vd, iDC_En, iDC_Dat, iIOB_Full,
        input  oDC_En, oDC_Rw, oDC_Len, oDC_Add, oDC_Dat,
        input  oRS_En, oRS_Qd, oRS_Vd, oROB_En, oROB_Qd, oROB_Vd, oIF_Full
    );

    modport slave (
        input  iROB_En, iROB_Op, iROB_Imm, iROB_Qs1, iROB_Qs2, iROB_Vs1, iROB_Vs2, iROB_Qd,
        input  iROB_Cs, iROB_Mp, iEX_En, iEX_Qd, iEX_Vd, iDC_En, iDC_Dat, iIOB_Full,
        output oDC_En, oDC_Rw, oDC_Len, oDC_Add, oDC_Dat,
        output oRS_En, oRS_Qd, oRS_Vd, oROB_En, oROB_Qd, oROB_Vd, oIF_Full
    );
endinterface

// File: rtl/lsb_gen.sv
// rtl/lsb_gen.sv - in-order load/store buffer with operand wakeup, flush and drain
module lsb_gen #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int TAG_W       = 5,
    parameter int DAT_W       = 32,
    parameter int OP_W        = 5,
    parameter int CDB_N       = 2,
    parameter int FULL_MARGIN = 2
) (
    input logic      clk,
    input logic      rst,
    input logic      en,
    lsb_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH - FULL_MARGIN);
    localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

    logic [OP_W-1:0]   e_op  [DEPTH];
    logic [DAT_W-1:0]  e_imm [DEPTH];
    logic [TAG_W-1:0]  e_qs1 [DEPTH];
    logic [TAG_W-1:0]  e_qs2 [DEPTH];
    logic [DAT_W-1:0]  e_vs1 [DEPTH];
    logic [DAT_W-1:0]  e_vs2 [DEPTH];
    logic [TAG_W-1:0]  e_qd  [DEPTH];

    logic [ADDR_W-1:0] head, tail;
    logic [ADDR_W:0]   count, ncs;
    state_t            state, state_next;

    logic              dc_en, dc_rw;
    logic [2:0]        dc_len;
    logic [DAT_W-1:0]  dc_add, dc_dat;
    logic              rs_en;
    logic [TAG_W-1:0]  rs_qd;
    logic [DAT_W-1:0]  rs_vd;

    logic [TAG_W-1:0]  cdb_qd [CDB_N];
    logic [DAT_W-1:0]  cdb_vd [CDB_N];
    logic [OP_W-1:0]   h_op;
    logic              h_load, h_store, h_ready;
    logic              push, pop, issue;
    logic [TAG_W-1:0]  p_qs1, p_qs2;
    logic [DAT_W-1:0]  p_vs1, p_vs2;
    logic [ADDR_W-1:0] head_f, tail_f;
    logic [ADDR_W:0]   ncs_f, count_f;
    logic              inflight_st;

    function automatic logic [DAT_W-1:0] load_ext(input logic [OP_W-1:0] op, input logic [DAT_W-1:0] d);
        logic [DAT_W-1:0] r;
        r = d;
        if (op == OP_LB)       r = {{(DAT_W-8){d[7]}}, d[7:0]};
        else if (op == OP_LH)  r = {{(DAT_W-16){d[15]}}, d[15:0]};
        else if (op == OP_LBU) r = {{(DAT_W-8){1'b0}}, d[7:0]};
        else if (op == OP_LHU) r = {{(DAT_W-16){1'b0}}, d[15:0]};
        return r;
    endfunction

    function automatic logic [2:0] op_len(input logic [OP_W-1:0] op);
        logic [2:0] l;
        l = 3'd4;
        if (op == OP_LB || op == OP_LBU || op == OP_SB)      l = 3'd1;
        else if (op == OP_LH || op == OP_LHU || op == OP_SH) l = 3'd2;
        return l;
    endfunction

    assign h_op    = e_op[head];
    assign h_load  = (h_op == OP_LB) || (h_op == OP_LH) || (h_op == OP_LW) ||
                     (h_op == OP_LBU) || (h_op == OP_LHU);
    assign h_store = (h_op == OP_SB) || (h_op == OP_SH) || (h_op == OP_SW);
    assign h_ready = (e_qs1[head] == '0) && (e_qs2[head] == '0);

    assign bus.oIF_Full = (count >= FULL_LVL);
    assign bus.oDC_En   = dc_en;
    assign bus.oDC_Rw   = dc_rw;
    assign bus.oDC_Len  = dc_len;
    assign bus.oDC_Add  = dc_add;
    assign bus.oDC_Dat  = dc_dat;
    assign bus.oRS_En   = rs_en;
    assign bus.oRS_Qd   = rs_qd;
    assign bus.oRS_Vd   = rs_vd;
    assign bus.oROB_En  = rs_en;
    assign bus.oROB_Qd  = rs_qd;
    assign bus.oROB_Vd  = rs_vd;

    // unpack broadcast ports and resolve push operands; load result first so lower ports override
    always_comb begin
        for (int k = 0; k < CDB_N; k++) begin
            cdb_qd[k] = bus.iEX_Qd[k*TAG_W +: TAG_W];
            cdb_vd[k] = bus.iEX_Vd[k*DAT_W +: DAT_W];
        end
        p_qs1 = bus.iROB_Qs1;
        p_vs1 = bus.iROB_Vs1;
        p_qs2 = bus.iROB_Qs2;
        p_vs2 = bus.iROB_Vs2;
        if (rs_en && bus.iROB_Qs1 != '0 && bus.iROB_Qs1 == rs_qd) begin
            p_qs1 = '0;
            p_vs1 = rs_vd;
        end
        if (rs_en && bus.iROB_Qs2 != '0 && bus.iROB_Qs2 == rs_qd) begin
            p_qs2 = '0;
            p_vs2 = rs_vd;
        end
        for (int k = CDB_N-1; k >= 0; k--) begin
            if (bus.iEX_En[k] && bus.iROB_Qs1 != '0 && bus.iROB_Qs1 == cdb_qd[k]) begin
                p_qs1 = '0;
                p_vs1 = cdb_vd[k];
            end
            if (bus.iEX_En[k] && bus.iROB_Qs2 != '0 && bus.iROB_Qs2 == cdb_qd[k]) begin
                p_qs2 = '0;
                p_vs2 = cdb_vd[k];
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next-state logic; a flush with a pending load and no response parks in DRAIN
    always_comb begin
        state_next = state;
        if (bus.iROB_Mp) begin
            if (state == BUSY)
                state_next = bus.iDC_En ? IDLE : (h_load ? DRAIN : BUSY);
            else if (state == DRAIN)
                state_next = bus.iDC_En ? IDLE : DRAIN;
        end else if (en) begin
            case (state)
                IDLE:    if (issue) state_next = BUSY;
                BUSY:    if (bus.iDC_En) state_next = IDLE;
                DRAIN:   if (bus.iDC_En) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // per-cycle decisions: push, pop, issue, and the queue shape after a flush
    always_comb begin
        push  = bus.iROB_En && (count != DEPTH_C);
        pop   = (state == BUSY) && bus.iDC_En;
        issue = (state == IDLE) && (count != '0) && h_ready &&
                (h_load || (h_store && (ncs != '0 || bus.iROB_Cs) && !bus.iIOB_Full));
        ncs_f       = ncs + (ADDR_W+1)'(bus.iROB_Cs);
        head_f      = head;
        inflight_st = 1'b0;
        if (state == BUSY) begin
            if (bus.iDC_En || h_load) head_f = head + ADDR_W'(1);
            else                      inflight_st = 1'b1;
        end
        tail_f  = head_f + ncs_f[ADDR_W-1:0] + ADDR_W'(inflight_st);
        count_f = ncs_f + (ADDR_W+1)'(inflight_st);
    end

    // queue storage, pointers, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_op[i]  <= '0;
                e_imm[i] <= '0;
                e_qs1[i] <= '0;
                e_qs2[i] <= '0;
                e_vs1[i] <= '0;
                e_vs2[i] <= '0;
                e_qd[i]  <= '0;
            end
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            ncs    <= '0;
            dc_en  <= 1'b0;
            dc_rw  <= 1'b0;
            dc_len <= '0;
            dc_add <= '0;
            dc_dat <= '0;
            rs_en  <= 1'b0;
            rs_qd  <= '0;
            rs_vd  <= '0;
        end else if (bus.iROB_Mp) begin
            head  <= head_f;
            tail  <= tail_f;
            count <= count_f;
            ncs   <= ncs_f;
            dc_en <= 1'b0;
            rs_en <= 1'b0;
            rs_qd <= '0;
            rs_vd <= '0;
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rs_en && e_qs1[i] != '0 && e_qs1[i] == rs_qd) begin
                    e_qs1[i] <= '0;
                    e_vs1[i] <= rs_vd;
                end
                if (rs_en && e_qs2[i] != '0 && e_qs2[i] == rs_qd) begin
                    e_qs2[i] <= '0;
                    e_vs2[i] <= rs_vd;
                end
                for (int k = CDB_N-1; k >= 0; k--) begin
                    if (bus.iEX_En[k] && e_qs1[i] != '0 && e_qs1[i] == cdb_qd[k]) begin
                        e_qs1[i] <= '0;
                        e_vs1[i] <= cdb_vd[k];
                    end
                    if (bus.iEX_En[k] && e_qs2[i] != '0 && e_qs2[i] == cdb_qd[k]) begin
                        e_qs2[i] <= '0;
                        e_vs2[i] <= cdb_vd[k];
                    end
                end
            end
            if (push) begin
                e_op[tail]  <= bus.iROB_Op;
                e_imm[tail] <= bus.iROB_Imm;
                e_qs1[tail] <= p_qs1;
                e_qs2[tail] <= p_qs2;
                e_vs1[tail] <= p_vs1;
                e_vs2[tail] <= p_vs2;
                e_qd[tail]  <= bus.iROB_Qd;
                tail        <= tail + ADDR_W'(1);
            end
            if (pop) head <= head + ADDR_W'(1);
            count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            ncs   <= ncs + (ADDR_W+1)'(bus.iROB_Cs) - (ADDR_W+1)'(issue && h_store);
            dc_en <= issue;
            if (issue) begin
                dc_rw  <= h_store;
                dc_len <= op_len(h_op);
                dc_add <= e_vs1[head] + e_imm[head];
                dc_dat <= e_vs2[head];
            end
            rs_en <= pop && h_load;
            rs_qd <= (pop && h_load) ? e_qd[head] : '0;
            rs_vd <= (pop && h_load) ? load_ext(h_op, bus.iDC_Dat) : '0;
        end
    end
endmodule

// File: doc/lsb_gen.md
# lsb_gen

Parametrised load/store buffer between the ROB dispatch path and the data cache. It holds memory ops in program order in a circular queue and tracks source operands through `CDB_N` broadcast ports. It issues the head op to the cache once its operands are ready and, for stores, once the ROB has committed it. Load results are broadcast back to the ROB/RS. Compared with the single-port buffer it replaces, it adds:

- an exact occupancy counter with a programmable full margin;
- a full-width committed-store counter;
- same-cycle bypass on push;
- a DRAIN state that absorbs cache responses for loads flushed by misprediction.

## Interface
Parameters:
- `DEPTH`, 16: queue entries; power of two, ≥4
- `ADDR_W`, 4: log2(`DEPTH`)
- `TAG_W`, 5: ROB tag width; tag 0 means "value ready"
- `DAT_W`, 32: data/address width
- `OP_W`, 5: opcode width; 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
- `CDB_N`, 2: number of execution broadcast ports
- `FULL_MARGIN`, 2: `oIF_Full` asserts when free slots ≤ `FULL_MARGIN`

Ports:
- `clk`  in  1  clock; one clock, all state on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  global stall; 0 freezes all state except `rst`/`iROB_Mp`
- `iROB_En`, `iROB_Op`[OP_W], `iROB_Imm`[DAT_W], `iROB_Qs1`/`iROB_Qs2`[TAG_W], `iROB_Vs1`/`iROB_Vs2`[DAT_W], `iROB_Qd`[TAG_W]  in  dispatch push
- `iROB_Cs`  in  1  one store committed this cycle
- `iROB_Mp`  in  1  misprediction flush
- `iEX_En`[CDB_N], `iEX_Qd`[CDB_N*TAG_W], `iEX_Vd`[CDB_N*DAT_W]  in  packed broadcast ports, port k at slice k
- `oDC_En`  out  1  one-cycle request pulse
- `oDC_Rw`  out  1  0 read, 1 write
- `oDC_Len`  out  3  1/2/4 bytes
- `oDC_Add`  out  DAT_W  request address
- `oDC_Dat`  out  DAT_W  store data
- `iDC_En`  in  1  request complete
- `iDC_Dat`  in  DAT_W  load data, zero-extended by cache
- `oRS_En`/`oROB_En`  out  1  load result valid
- `oRS_Qd`/`oROB_Qd`  out  TAG_W  load result tag
- `oRS_Vd`/`oROB_Vd`  out  DAT_W  load result value
- `iIOB_Full`  in  1  blocks store issue
- `oIF_Full`  out  1  backpressure to fetch

## Operation
- **Queue:** `head`/`tail` are `ADDR_W` bits and wrap mod `DEPTH`. `count` is `ADDR_W+1` bits. `ncs` (committed, unissued stores) is `ADDR_W+1` bits.
- **Full flag:** `oIF_Full = (count ≥ DEPTH−FULL_MARGIN)`, combinational. A push while `count==DEPTH` is ignored.
- **Push:** writes the entry at `tail`. Bypass: if `iROB_QsX` matches any active `iEX_Qd` port, or this cycle's load-result tag, the entry stores that value with tag 0. The lowest port index wins on a duplicate tag.
- **Update:** each active CDB port, and each load completion, clears every matching `qs1`/`qs2` and writes the corresponding `vs`.
- **FSM, IDLE:** issue when the queue is non-empty and the head has `qs1==qs2==0`.
  - Load: issue immediately.
  - Store: issue only if `(ncs≠0 || iROB_Cs) && !iIOB_Full`.
  - On issue, drive `oDC_Add=vs1+imm` (mod 2^DAT_W), `oDC_Dat=vs2`, `oDC_Rw`, and `oDC_Len` from the opcode, then go to BUSY.
- **FSM, BUSY:** on `iDC_En`, pop the head and go to IDLE. For a load, also present the result.
- **FSM, DRAIN:** entered only via flush; on `iDC_En`, discard the data and go to IDLE. Nothing issues in DRAIN.
- **Load extension:** LB sign-extends bit 7; LH sign-extends bit 15; LBU/LHU zero-extend; LW passes through.
- **`ncs` update:** `+iROB_Cs`, `−1` on store issue; both in the same cycle leaves it unchanged.
- **Flush (`iROB_Mp`):** keeps committed stores, drops everything else.
  - `iROB_Cs` in the same cycle is counted first.
  - A push in the same cycle is ignored.
  - `tail = head + ncs'`, plus 1 if a store is in flight at head. `count` is recomputed to match.
  - In-flight load without `iDC_En`: go to DRAIN, and the head entry is dropped.
  - In-flight op with `iDC_En` in the same cycle: the pop completes first, with no load output, and the FSM goes to IDLE.
  - All result outputs deassert.
- **Priority:** `rst` > `iROB_Mp` > `en`.

## Timing
- **Reset values:** all `o*` outputs 0; `head=tail=count=ncs=0`; FSM IDLE; all entries cleared.
- **Issue latency:** an entry pushed in cycle N with ready operands raises `oDC_En` at cycle N+2 (registered in N+1) if it is at head.
- **Request hold:** `oDC_En` is high for exactly one cycle. `oDC_Add`/`oDC_Dat`/`oDC_Len`/`oDC_Rw` are held stable until `iDC_En`.
- **Load result:** `iDC_En` in cycle M gives `oRS_En=oROB_En=1` in M+1, held for one cycle.
- **Back-to-back issue:** the next head can issue in M+1 (`oDC_En` at M+1 edge).
- **Simultaneous push and pop:** `count` unchanged.

## Test plan
- Reset, then push LW with Vs1=0x100, Imm=4, ready tags → `oDC_En` pulse with Add=0x104, Len=4, Rw=0. Respond `iDC_Dat=0xDEADBEEF` → `oROB_En` next cycle with Vd=0xDEADBEEF and correct Qd.
- LB/LH/LBU/LHU with `iDC_Dat=0x000080F0` → Vd=0xFFFFFFF0, 0xFFFF80F0, 0x000000F0, 0x000080F0 respectively.
- Push SW with Qs2=7; broadcast tag 7=0x55 on port 1 in the same cycle as the push → entry ready. No issue until `iROB_Cs`; then Rw=1, Dat=0x55.
- Fill the queue with `DEPTH` loads whose Qs1=3 is pending → `oIF_Full` rises at `count=DEPTH−2`. An extra push is ignored. Broadcast tag 3 and drain → all `DEPTH` results come back in order across the wrap.
- Two committed stores plus three loads queued, load in flight, then `iROB_Mp` → FSM DRAIN, the late `iDC_En` produces no output, `tail=head+2`, and both stores then issue.
- `iROB_Mp` coincident with `iDC_En` for a head store, with `ncs=1` → store popped, one store remains, `count=1`.
